// File: rtl/bitstream_tx_if.sv
// Handshake and serial-output bundle between a frame source and bitstream_tx.
// The master drives frame requests and payload words; the slave serialises them.
interface bitstream_tx_if #(
    parameter int HEADER_WIDTH = 32,
    parameter int WORD_WIDTH   = 32
);
    logic                    start;
    logic [3:0]              instr;
    logic [HEADER_WIDTH-5:0] len;
    logic [WORD_WIDTH-1:0]   word_i;
    logic                    word_valid;
    logic                    word_ready;
    logic                    data_o;
    logic                    en_o;
    logic                    busy;
    logic                    done;
    logic                    underrun;

    modport master (
        output start, instr, len, word_i, word_valid,
        input  word_ready, data_o, en_o, busy, done, underrun
    );

    modport slave (
        input  start, instr, len, word_i, word_valid,
        output word_ready, data_o, en_o, busy, done, underrun
    );
endinterface

// File: rtl/bitstream_tx.sv
// Serial frame transmitter: enable strobe, LSB-first header, streamed
// payload words, then a drain gap before the next frame can start.
module bitstream_tx #(
    parameter int HEADER_WIDTH = 32,
    parameter int WORD_WIDTH   = 32,
    parameter int GAP_CYCLES   = 16
) (
    input  logic           clk,
    input  logic           rst,
    bitstream_tx_if.slave  bus
);
    localparam int LW  = HEADER_WIDTH - 4;
    localparam int HCW = $clog2(HEADER_WIDTH);
    localparam int BCW = $clog2(WORD_WIDTH);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [HCW-1:0] HLAST = HCW'(HEADER_WIDTH - 1);
    localparam logic [BCW-1:0] BLAST = BCW'(WORD_WIDTH - 1);
    localparam logic [GCW-1:0] GLAST = GCW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN,
        S_HDR,
        S_PAY,
        S_GAP
    } state_t;

    state_t                  r_state, w_state;
    logic [HEADER_WIDTH-1:0] r_hdr, w_hdr;
    logic [WORD_WIDTH-1:0]   r_word, w_word;
    logic [LW-1:0]           r_rem, w_rem;
    logic [HCW-1:0]          r_hcnt, w_hcnt;
    logic [BCW-1:0]          r_bcnt, w_bcnt;
    logic [GCW-1:0]          r_gcnt, w_gcnt;
    logic                    r_data, w_data;
    logic                    r_en, w_en;
    logic                    r_busy, w_busy;
    logic                    r_done, w_done;
    logic                    r_und, w_und;
    logic                    w_ready;
    logic                    w_xfer;

    // r_rem still holds len during HDR and counts down through PAY
    assign w_ready = ((r_state == S_HDR) && (r_hcnt == HLAST) && (r_rem != '0))
                  || ((r_state == S_PAY) && (r_bcnt == BLAST) && (r_rem > LW'(1)));
    assign w_xfer  = w_ready & bus.word_valid;

    always_comb begin
        w_state = r_state;
        w_hdr   = r_hdr;
        w_word  = r_word;
        w_rem   = r_rem;
        w_hcnt  = r_hcnt;
        w_bcnt  = r_bcnt;
        w_gcnt  = r_gcnt;
        w_data  = 1'b0;
        w_en    = 1'b0;
        w_done  = 1'b0;
        w_und   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // the done cycle is IDLE but must not accept a new frame
                if (bus.start && !r_done) begin
                    w_state = S_EN;
                    w_hdr   = {bus.len, bus.instr};
                    w_rem   = bus.len;
                    w_hcnt  = '0;
                    w_en    = 1'b1;
                end
            end
            S_EN: begin
                w_state = S_HDR;
                w_data  = r_hdr[0];
                w_hdr   = r_hdr >> 1;
                w_hcnt  = '0;
            end
            S_HDR: begin
                if (r_hcnt != HLAST) begin
                    w_data = r_hdr[0];
                    w_hdr  = r_hdr >> 1;
                    w_hcnt = r_hcnt + HCW'(1);
                end else if (r_rem == '0) begin
                    w_state = S_GAP;
                    w_gcnt  = '0;
                end else if (w_xfer) begin
                    w_state = S_PAY;
                    w_data  = bus.word_i[0];
                    w_word  = bus.word_i >> 1;
                    w_bcnt  = '0;
                end else begin
                    w_state = S_IDLE;
                    w_und   = 1'b1;
                end
            end
            S_PAY: begin
                w_rem = r_rem - LW'(1);
                if (r_rem == LW'(1)) begin
                    w_state = S_GAP;
                    w_gcnt  = '0;
                end else if (r_bcnt != BLAST) begin
                    w_data = r_word[0];
                    w_word = r_word >> 1;
                    w_bcnt = r_bcnt + BCW'(1);
                end else if (w_xfer) begin
                    w_data = bus.word_i[0];
                    w_word = bus.word_i >> 1;
                    w_bcnt = '0;
                end else begin
                    w_state = S_IDLE;
                    w_und   = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gcnt == GLAST) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_gcnt = r_gcnt + GCW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hdr   <= '0;
            r_word  <= '0;
            r_rem   <= '0;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_gcnt  <= '0;
            r_data  <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_hdr   <= w_hdr;
            r_word  <= w_word;
            r_rem   <= w_rem;
            r_hcnt  <= w_hcnt;
            r_bcnt  <= w_bcnt;
            r_gcnt  <= w_gcnt;
            r_data  <= w_data;
            r_en    <= w_en;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_und   <= w_und;
        end
    end

    assign bus.word_ready = w_ready;
    assign bus.data_o     = r_data;
    assign bus.en_o       = r_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.underrun   = r_und;
endmodule

// File: tb/tb_bitstream_tx.sv
// Bench for bitstream_tx: random and directed frames compared cycle by cycle
// against a frame-level timeline model.
module tb_bitstream_tx;
    localparam int HW = 32;
    localparam int WW = 32;
    localparam int G  = 16;
    localparam int LW = HW - 4;
    localparam int P  = 2 + HW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   hs;
    logic [WW-1:0] tb_words [0:7];
    logic [5:0]    obs [0:1023];

    bitstream_tx_if #(.HEADER_WIDTH(HW), .WORD_WIDTH(WW)) bus ();

    bitstream_tx #(
        .HEADER_WIDTH(HW),
        .WORD_WIDTH  (WW),
        .GAP_CYCLES  (G)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] cur_out();
        return {bus.data_o, bus.en_o, bus.busy,
                bus.done, bus.underrun, bus.word_ready};
    endfunction

    // Expected {data,en,busy,done,underrun,ready} at cycle c after start
    function automatic logic [5:0] exp_vec(int c, logic [3:0] ins,
                                           int ln, int drop);
        logic [HW-1:0] hdr;
        logic [WW-1:0] w;
        logic dat, en, bsy, dn, rdy;
        int nw, d, r, j;
        hdr = {LW'(ln), ins};
        nw  = (ln + WW - 1) / WW;
        d   = P + ln + G;
        r   = P - 1 + drop * WW;
        dat = 0; en = 0; bsy = 0; dn = 0; rdy = 0;
        if (drop >= 0 && drop < nw && c > r)
            return {4'b0, (c == r + 1), 1'b0};
        if (c == 1) begin
            en = 1; bsy = 1;
        end else if (c >= 2 && c < P) begin
            dat = hdr[c-2]; bsy = 1;
        end else if (c >= P && c < P + ln) begin
            j = c - P;
            w = tb_words[j/WW];
            dat = w[j%WW]; bsy = 1;
        end else if (c >= P + ln && c < d) begin
            bsy = 1;
        end else if (c == d) begin
            dn = 1;
        end
        if (ln > 0 && c >= P - 1 && (c - (P - 1)) % WW == 0
            && (c - (P - 1)) / WW < nw)
            rdy = 1;
        return {dat, en, bsy, dn, 1'b0, rdy};
    endfunction

    task automatic drive_frame(input logic [3:0] ins, input int ln,
                               input int drop, input bit hold,
                               input int ncyc);
        int nw;
        nw = (ln + WW - 1) / WW;
        hs = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.start = 1'b1;
                bus.instr = ins;
                bus.len   = LW'(ln);
            end else if (!hold) begin
                bus.start = 1'b0;
            end
            bus.word_i     = tb_words[(nw > 0) ? hs % nw : 0];
            bus.word_valid = (hs != drop);
            @(negedge clk);
            obs[c] = cur_out();
            if (bus.word_ready && bus.word_valid) hs++;
        end
        bus.start      = 1'b0;
        bus.word_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (cur_out() !== 6'b0) begin
                n_fail++;
                $display("FAIL reset c%0d: got %b want 000000", c, cur_out());
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_key_frame();
        logic [5:0] e;
        int d;
        for (int i = 0; i < 4; i++) tb_words[i] = $urandom;
        d = P + 128 + G;
        drive_frame(4'd3, 128, -1, 0, d + 2);
        for (int c = 0; c < d + 2; c++) begin
            e = exp_vec(c, 4'd3, 128, -1);
            n_chk++;
            if (obs[c] !== e) begin
                n_fail++;
                $display("FAIL key c%0d: got %b want %b", c, obs[c], e);
            end
        end
        n_chk++;
        if (obs[1][4] !== 1'b1 || obs[162+G][2] !== 1'b1) begin
            n_fail++;
            $display("FAIL key_marks: en1=%b done=%b want 1 1",
                     obs[1][4], obs[162+G][2]);
        end
        n_chk++;
        if (hs !== 4) begin
            n_fail++;
            $display("FAIL key_hs: got %0d want 4", hs);
        end
    endtask

    task automatic test_mem_frame();
        logic [5:0] e;
        int d;
        tb_words[0] = 32'hA5A5A5A5;
        tb_words[1] = 32'h000000FF;
        d = P + 40 + G;
        drive_frame(4'd1, 40, -1, 0, d + 2);
        for (int c = 0; c < d + 2; c++) begin
            e = exp_vec(c, 4'd1, 40, -1);
            n_chk++;
            if (obs[c] !== e) begin
                n_fail++;
                $display("FAIL mem c%0d: got %b want %b", c, obs[c], e);
            end
        end
        n_chk++;
        if (hs !== 2) begin
            n_fail++;
            $display("FAIL mem_hs: got %0d want 2", hs);
        end
    endtask

    task automatic test_len_zero();
        logic [5:0] e;
        int d;
        d = P + G;
        drive_frame(4'd2, 0, -1, 0, d + 2);
        for (int c = 0; c < d + 2; c++) begin
            e = exp_vec(c, 4'd2, 0, -1);
            n_chk++;
            if (obs[c] !== e) begin
                n_fail++;
                $display("FAIL len0 c%0d: got %b want %b", c, obs[c], e);
            end
        end
        n_chk++;
        if (hs !== 0) begin
            n_fail++;
            $display("FAIL len0_hs: got %0d want 0", hs);
        end
    endtask

    task automatic test_underrun();
        logic [5:0] e;
        int n, d;
        for (int i = 0; i < 2; i++) tb_words[i] = $urandom;
        n = P - 1 + WW + 4;
        drive_frame(4'd1, 64, 1, 0, n);
        for (int c = 0; c < n; c++) begin
            e = exp_vec(c, 4'd1, 64, 1);
            n_chk++;
            if (obs[c] !== e) begin
                n_fail++;
                $display("FAIL underrun c%0d: got %b want %b", c, obs[c], e);
            end
        end
        n_chk++;
        if (hs !== 1) begin
            n_fail++;
            $display("FAIL underrun_hs: got %0d want 1", hs);
        end
        d = P + 64 + G;
        drive_frame(4'd0, 64, -1, 0, d + 2);
        for (int c = 0; c < d + 2; c++) begin
            e = exp_vec(c, 4'd0, 64, -1);
            n_chk++;
            if (obs[c] !== e) begin
                n_fail++;
                $display("FAIL after_ur c%0d: got %b want %b", c, obs[c], e);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [5:0] e;
        int d;
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk); #1;
            bus.start = (c == 0);
            bus.instr = 4'd1;
            bus.len   = LW'(64);
        end
        n_chk++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: busy got %b want 1", bus.busy);
        end
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (cur_out() !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got %b want 000000", cur_out());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cur_out() !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_rel: got %b want 000000", cur_out());
        end
        for (int i = 0; i < 2; i++) tb_words[i] = $urandom;
        d = P + 50 + G;
        drive_frame(4'd1, 50, -1, 0, d + 2);
        for (int c = 0; c < d + 2; c++) begin
            e = exp_vec(c, 4'd1, 50, -1);
            n_chk++;
            if (obs[c] !== e) begin
                n_fail++;
                $display("FAIL rst_after c%0d: got %b want %b", c, obs[c], e);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] e;
        logic [3:0] ins;
        int ln, nw, drop, n;
        for (int it = 0; it < 8; it++) begin
            ln  = $urandom_range(0, 256);
            ins = 4'($urandom_range(0, 3));
            nw  = (ln + WW - 1) / WW;
            for (int i = 0; i < 8; i++) tb_words[i] = $urandom;
            drop = -1;
            if (nw > 0 && $urandom_range(0, 2) == 0)
                drop = $urandom_range(0, nw - 1);
            n = (drop >= 0) ? P - 1 + drop * WW + 4 : P + ln + G + 2;
            drive_frame(ins, ln, drop, 0, n);
            for (int c = 0; c < n; c++) begin
                e = exp_vec(c, ins, ln, drop);
                n_chk++;
                if (obs[c] !== e) begin
                    n_fail++;
                    $display("FAIL rand%0d len%0d drop%0d c%0d: got %b want %b",
                             it, ln, drop, c, obs[c], e);
                end
            end
            n_chk++;
            if (hs !== ((drop >= 0) ? drop : nw)) begin
                n_fail++;
                $display("FAIL rand%0d_hs: got %0d want %0d",
                         it, hs, (drop >= 0) ? drop : nw);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        int d;
        for (int i = 0; i < 2; i++) tb_words[i] = $urandom;
        d = P + 40 + G;
        drive_frame(4'd2, 40, -1, 1, 2 * d + 2);
        for (int c = 0; c < 2 * d + 2; c++) begin
            e = (c <= d) ? exp_vec(c, 4'd2, 40, -1)
                         : exp_vec(c - d - 1, 4'd2, 40, -1);
            n_chk++;
            if (obs[c] !== e) begin
                n_fail++;
                $display("FAIL b2b c%0d: got %b want %b", c, obs[c], e);
            end
        end
        n_chk++;
        if (hs !== 4) begin
            n_fail++;
            $display("FAIL b2b_hs: got %0d want 4", hs);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.instr      = 4'd0;
        bus.len        = '0;
        bus.word_i     = '0;
        bus.word_valid = 1'b0;
        test_reset();
        test_key_frame();
        test_mem_frame();
        test_len_zero();
        test_underrun();
        test_rst_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
